inst_mem_loader: RTL
====================

// Module: inst_mem_loader
// PURPOSE
//   Boot loader: the write side of the 1024-word instruction memory.
//   - Takes a byte stream with a valid/ready handshake, typically from the UART receiver.
//   - Parses a framed program image.
//   - Assembles little-endian 32-bit words and issues one-cycle writes to the memory write port.
//   - Holds the CPU in reset while a load is in progress.
// PARAMETERS
//   ADDR_W     10     word-address width; memory depth is 2**ADDR_W words
//   SYNC_BYTE  8'hA5  frame start marker
// PORTS
//   clk         in   1       system clock, all logic on rising edge
//   rst         in   1       synchronous, active-high reset
//   rx_data     in   8       incoming byte
//   rx_valid    in   1       rx_data valid this cycle
//   rx_ready    out  1       loader accepts byte; transfer = rx_valid & rx_ready
//   mem_we      out  1       instruction-memory write strobe, one cycle per word
//   mem_waddr   out  ADDR_W  word address (memory indexed by word, not byte)
//   mem_wdata   out  32      word to write
//   cpu_hold    out  1       1 = keep CPU in reset, PC held at 0
//   load_done   out  1       sticky: last frame loaded with good checksum
//   load_err    out  1       sticky: last frame rejected
// BEHAVIOUR
//   Frame format:
//     SYNC_BYTE, CNT_LO, CNT_HI, then CNT words (4 bytes each, LSB first), then CSUM.
//     CSUM = 8-bit wrap-around sum of all word bytes, excluding sync, count and CSUM itself.
//   Reset values:
//     rx_ready=1, mem_we=0, mem_waddr=0, mem_wdata=0,
//     cpu_hold=0, load_done=0, load_err=0; state=IDLE.
//   States and transitions:
//     IDLE   accept bytes; non-sync bytes are dropped silently.
//            On SYNC_BYTE: cpu_hold<=1, done/err<=0, go CNT0.
//     CNT0   latch CNT_LO -> CNT1.
//     CNT1   latch CNT_HI.
//            If CNT==0 or CNT>2**ADDR_W: err<=1, go ERR.
//            Otherwise word index<=0, csum<=0, go DATA.
//     DATA   byte k (0..3) goes into bits [8k+7:8k] and is added to csum.
//            After the 4th byte go WRITE.
//     WRITE  exactly one cycle:
//              mem_we=1, mem_waddr=word index, mem_wdata=assembled word; rx_ready=0.
//            Then index++. Go CSUM if index==CNT, else DATA.
//     CSUM   on accepted byte:
//              match    -> load_done<=1, cpu_hold<=0, go IDLE.
//              mismatch -> load_err<=1, go ERR.
//     ERR    cpu_hold stays 1; bytes accepted and dropped.
//            SYNC_BYTE restarts exactly as from IDLE (-> CNT0).
//   Handshake:
//     - rx_ready=0 only in WRITE. Every byte arriving with rx_valid=1 while rx_ready=0 is not consumed.
//     - Any state consumes at most one byte per cycle.
//   Write timing:
//     - mem_we rises the cycle after the 4th byte of a word is accepted.
//     - mem_waddr and mem_wdata are stable while mem_we=1 and hold their values after it.
//   SYNC_BYTE inside CNT/DATA/CSUM is treated as data, with no resync.
//   Word index is ADDR_W+1 bits so CNT=2**ADDR_W ends cleanly (last addr 2**ADDR_W-1, no wrap).
//   A rst asserted mid-frame aborts the load:
//     - All outputs return to reset values on the next edge, so cpu_hold drops.
//     - Words already written stay in memory.
// TESTING
//   1. A5,02,00,13,00,00,00,93,00,10,00,CSUM=B6 ->
//      writes 0x00000013@0 and 0x00100093@1; load_done=1, cpu_hold=0.
//   2. Same frame, wrong CSUM=00 -> both words written; load_err=1, cpu_hold=1;
//      then a resent good frame -> load_done=1, load_err=0.
//   3. Count 00,00, and separately 01,04 (1025) ->
//      load_err=1 immediately, no mem_we pulses.
//   4. Garbage 11,22 before A5 -> ignored, cpu_hold stays 0 until A5;
//      rx_valid held high continuously -> rx_ready low exactly one cycle per word,
//      no byte lost or duplicated.
//   5. rst asserted after 6 bytes of test 1 ->
//      outputs at reset values next cycle; a fresh frame then loads correctly.
//   6. CNT=1024 with word k=k -> 1024 writes, last mem_waddr=1023; load_done=1.

Source files
------------

// File: rtl/inst_mem_loader_if.sv
// inst_mem_loader_if: byte-stream input and instruction-memory write port of the boot loader
interface inst_mem_loader_if #(parameter int ADDR_W = 10);
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  logic mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic cpu_hold;
  logic load_done;
  logic load_err;
  modport master (
    input rx_data, rx_valid,
    output rx_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, load_done, load_err
  );
  modport slave (
    output rx_data, rx_valid,
    input rx_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, load_done, load_err
  );
endinterface

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: parses a framed byte stream into 32-bit instruction-memory writes
module inst_mem_loader #(
  parameter int ADDR_W = 10,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input logic clk,
  input logic rst,
  inst_mem_loader_if.master bus
);
  typedef enum logic [2:0] {IDLE, CNT0, CNT1, DATA, WRITE, CSUM, ERR} state_t;
  localparam logic [15:0] DEPTH = 16'(2**ADDR_W);
  state_t state_q;
  logic [7:0] cnt_lo_q;
  logic [ADDR_W:0] cnt_q;
  logic [ADDR_W:0] idx_q;
  logic [ADDR_W:0] idx_d;
  logic [15:0] cnt_d;
  logic [1:0] bcnt_q;
  logic [23:0] word_q;
  logic [7:0] csum_q;
  logic rx_ready_q;
  logic mem_we_q;
  logic [ADDR_W-1:0] mem_waddr_q;
  logic [31:0] mem_wdata_q;
  logic cpu_hold_q;
  logic load_done_q;
  logic load_err_q;
  logic acc;
  assign acc = bus.rx_valid & rx_ready_q;
  assign cnt_d = {bus.rx_data, cnt_lo_q};
  assign idx_d = idx_q + 1'b1;
  assign bus.rx_ready = rx_ready_q;
  assign bus.mem_we = mem_we_q;
  assign bus.mem_waddr = mem_waddr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_hold = cpu_hold_q;
  assign bus.load_done = load_done_q;
  assign bus.load_err = load_err_q;
  // Frame parser; bytes arrive LSB first and are shifted in from the top so the
  // first three form the low 24 bits by the time the fourth byte arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_lo_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      bcnt_q <= '0;
      word_q <= '0;
      csum_q <= '0;
      rx_ready_q <= 1'b1;
      mem_we_q <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        IDLE, ERR: if (acc && bus.rx_data == SYNC_BYTE) begin
          cpu_hold_q <= 1'b1;
          load_done_q <= 1'b0;
          load_err_q <= 1'b0;
          state_q <= CNT0;
        end
        CNT0: if (acc) begin
          cnt_lo_q <= bus.rx_data;
          state_q <= CNT1;
        end
        CNT1: if (acc) begin
          if (cnt_d == '0 || cnt_d > DEPTH) begin
            load_err_q <= 1'b1;
            state_q <= ERR;
          end else begin
            cnt_q <= cnt_d[ADDR_W:0];
            idx_q <= '0;
            csum_q <= '0;
            bcnt_q <= '0;
            state_q <= DATA;
          end
        end
        DATA: if (acc) begin
          word_q <= {bus.rx_data, word_q[23:8]};
          csum_q <= csum_q + bus.rx_data;
          bcnt_q <= bcnt_q + 1'b1;
          if (bcnt_q == 2'd3) begin
            mem_we_q <= 1'b1;
            mem_waddr_q <= idx_q[ADDR_W-1:0];
            mem_wdata_q <= {bus.rx_data, word_q};
            rx_ready_q <= 1'b0;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          rx_ready_q <= 1'b1;
          idx_q <= idx_d;
          state_q <= (idx_d == cnt_q) ? CSUM : DATA;
        end
        CSUM: if (acc) begin
          if (bus.rx_data == csum_q) begin
            load_done_q <= 1'b1;
            cpu_hold_q <= 1'b0;
            state_q <= IDLE;
          end else begin
            load_err_q <= 1'b1;
            state_q <= ERR;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
